// File: rtl/multi_clk_div_pkg.sv
// multi_clk_div_pkg: shared widths, default ratio and off-threshold for the multi-channel divider.
package multi_clk_div_pkg;
  localparam int RATIO_W = 8;
  localparam int CH_W = 4;
  localparam int DEFAULT_RATIO = 80;
  localparam int RATIO_OFF_MAX = 1;
  typedef logic [RATIO_W-1:0] ratio_t;
endpackage

// File: rtl/div_channel.sv
// div_channel: one divider channel with shadowed ratio applied at period end.
// Optional MULTI_CLK_DIV_TICK_EN adds a single-cycle pulse on each rising edge of o_div.
module div_channel
  import multi_clk_div_pkg::*;
#(
  parameter int W = RATIO_W,
  parameter int DEF_RATIO = DEFAULT_RATIO
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_ratio,
  output logic         o_pending,
`ifdef MULTI_CLK_DIV_TICK_EN
  output logic         o_tick,
`endif
  output logic         o_div
);
  logic [W-1:0] r_cnt, r_ratio, r_shadow;
  logic r_pending, r_div;
  logic w_off, w_term, w_high;
  assign w_off = r_ratio <= W'(RATIO_OFF_MAX);
  assign w_term = r_cnt == r_ratio - W'(1);
  assign w_high = r_cnt < (r_ratio >> 1);
  assign o_pending = r_pending;
  assign o_div = r_div;
  // apply check reads the pre-edge pending, so a write on the terminal edge waits a full period
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_ratio <= W'(DEF_RATIO);
      r_shadow <= W'(DEF_RATIO);
      r_pending <= 1'b0;
      r_div <= 1'b0;
    end else if (i_sync) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_pending <= 1'b0;
      r_ratio <= i_wr ? i_ratio : r_pending ? r_shadow : r_ratio;
    end else begin
      if (w_off) begin
        r_cnt <= '0;
        r_div <= 1'b0;
      end else if (i_en) begin
        r_div <= w_high;
        r_cnt <= w_term ? '0 : r_cnt + W'(1);
      end
      if (r_pending && (w_off || (i_en && w_term))) begin
        r_ratio <= r_shadow;
        r_pending <= 1'b0;
      end
      if (i_wr) begin
        r_shadow <= i_ratio;
        r_pending <= 1'b1;
      end
    end
  end
`ifdef MULTI_CLK_DIV_TICK_EN
  logic r_tick;
  assign o_tick = r_tick;
  always_ff @(posedge clk) begin
    r_tick <= reset && !i_sync && !w_off && i_en && w_high && !r_div;
  end
`endif
endmodule

// File: rtl/multi_clk_div.sv
// multi_clk_div: NCH-channel programmable integer clock divider with glitch-free ratio updates and global sync.
// Optional MULTI_CLK_DIV_TICK_EN adds the tick output (one pulse per div_out rising edge).
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W = RATIO_W,
  parameter int DEF_RATIO = DEFAULT_RATIO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            sync,
  input  logic            cfg_valid,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_ratio,
  output logic            cfg_ready,
  output logic [NCH-1:0]  div_out,
`ifdef MULTI_CLK_DIV_TICK_EN
  output logic [NCH-1:0]  tick,
`endif
  inout  wire             VDD,
  inout  wire             VSS
);
  logic [NCH-1:0] w_pending, w_wr;
  logic [2**CH_W-1:0] w_pend_x;
  logic w_unused_pwr;
  assign w_unused_pwr = VDD ^ VSS;
  // out-of-range channels read as never pending, so such writes are accepted and dropped
  always_comb begin
    w_pend_x = '0;
    w_pend_x[NCH-1:0] = w_pending;
  end
  assign cfg_ready = reset & ~w_pend_x[cfg_ch];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    div_channel #(.W(W), .DEF_RATIO(DEF_RATIO)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_en     (en),
      .i_sync   (sync),
      .i_wr     (w_wr[i]),
      .i_ratio  (cfg_ratio),
      .o_pending(w_pending[i]),
`ifdef MULTI_CLK_DIV_TICK_EN
      .o_tick   (tick[i]),
`endif
      .o_div    (div_out[i])
    );
  end
endmodule

// File: doc/multi_clk_div.md
Name: multi_clk_div

Overview:
- Parametrised multi-channel integer clock divider; successor to the fixed divide-by-4/8/80 block.
- NCH independent channels, each with a runtime-programmable divide ratio.
- Ratio updates take effect only at period boundaries, so they are glitch-free.
- Global sync realigns all channels; outputs are registered divided clocks for downstream clock-enable/clock-mux logic in the clock-generation subsystem.

Parameters:
- NCH, 4, number of divider channels (1..16).
- W, 8, ratio/counter width in bits; max ratio 2^W-1.
- DEF_RATIO, 80, ratio loaded into every channel at reset; must be >=2 and <2^W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- en  in  1  global count enable; 0 freezes all counters and outputs.
- sync  in  1  synchronous realign of all channels.
- cfg_valid  in  1  ratio write request.
- cfg_ch  in  4  target channel index.
- cfg_ratio  in  W  new divide ratio.
- cfg_ready  out  1  write accepted when cfg_valid&&cfg_ready.
- div_out  out  NCH  divided clock per channel.
- VDD  inout  1  power pin, no logic.
- VSS  inout  1  ground pin, no logic.

Behaviour:
- Reset (reset==0 at posedge): cnt=0, active ratio=DEF_RATIO, pending=0, div_out=0 for every channel; cfg_ready=0 during reset.
- Per channel, active ratio R, half H=R>>1. On each edge with en=1 and R>=2:
  - div_out <= (cnt < H).
  - cnt <= (cnt==R-1) ? 0 : cnt+1.
- Output is high for H edges and low for R-H edges; period is R. Odd R gives a short high phase, e.g. R=3 gives high 1, low 2.
- First rising edge of div_out is at the first enabled edge after reset release: one cycle of latency from the counter to div_out.
- R=0 or 1 means the channel is off: div_out <= 0 and cnt <= 0 on every edge regardless of en.
- en=0: cnt and div_out hold. The period is stretched by the number of disabled cycles.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] when cfg_ch<NCH.
  - cfg_ready = 1 when cfg_ch>=NCH; the write is accepted and dropped.
  - An accepted write stores cfg_ratio in the channel shadow register and sets pending.
- Pending apply:
  - On an enabled edge where cnt==R-1 and pending was already set before that edge, R <= shadow and pending <= 0. That edge itself still uses the old R.
  - An off channel (R<2) applies pending on the next edge even if en=0.
- Write on the terminal edge: the write goes to shadow and applies at the following period end, not the current one.
- sync=1 has priority over en and cfg apply:
  - All cnt <= 0, all div_out <= 0.
  - Any pending shadow is applied immediately and pending cleared.
  - A cfg write accepted in the same cycle as sync is applied immediately as well.
- After sync drops, all enabled channels rise on the same edge; this is the phase alignment guarantee.
- Counter arithmetic is W bits unsigned; no wrap beyond R-1 occurs.

Optional Feature:
- Macro MULTI_CLK_DIV_TICK_EN.
- When defined: adds output port tick (NCH bits). tick[i] is a registered single-cycle pulse coincident with each rising edge of div_out[i]. It is also 0 when the channel is off, en=0, or during reset.
- When undefined: no tick port and no tick registers.

Decomposition:
- Package multi_clk_div_pkg holds:
  - ratio_t (logic [W-1:0]) width constant.
  - DEF_RATIO default.
  - RATIO_OFF_MAX=1 constant.
  - Channel-index width constant.
- Sub-module div_channel owns cnt, active/shadow ratio, pending and div_out for one channel. The top instantiates NCH copies via generate and implements cfg decode, cfg_ready mux and sync fan-out.

Test Plan:
- Reset release, en=1, default 80 -> each div_out high 40 edges, low 40 edges, period 80; all channels in phase.
- Write ratio 3 to ch1 while running -> after the current 80-cycle period ends, ch1 repeats high 1 / low 2; other channels unchanged.
- Write 10 to ch2 at cnt=20 -> cfg_ready low for ch2 until period end, and a second write to ch2 during that time is not accepted. The current period completes at 80, then period is 10 (high 5, low 5).
- Write ratio 0 to ch3 -> within one edge after period end div_out[3]=0 and stays 0; write 4 -> output resumes next edge, high 2 / low 2.
- Pulse sync for 1 cycle mid-period -> all div_out 0 on the next edge, then all channels rise together on the first edge after sync drops.
- en=0 for 7 cycles at cnt=30 -> outputs and counters hold; that period measures 87 cycles; write to cfg_ch=9 is accepted and has no effect.
